contador_param: RTL and testbench

- Parametrised successor of the team's fixed 8-bit up-counter.
- Configurable width, modulus, up/down direction, synchronous clear/load, wrap or saturate mode, and an integrated clock-enable prescaler.
- Used as the generic timebase/event counter in datapaths and for cascading: the `wrap` output of one instance drives the `enable` input of the next.

---
 rtl/contador_pkg.sv | 37 +++
 rtl/contador_prescaler.sv | 41 ++++
 rtl/contador_param.sv | 126 ++++++++++++
 tb/tb_contador_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared constants, types and helpers for the parametrised counter family.
package contador_pkg;

   // Direction encoding of the up_down input
   localparam logic CNT_UP   = 1'b1;
   localparam logic CNT_DOWN = 1'b0;

   // Bound behaviour selected by the SATURATE parameter
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // What the counter register does on a given edge, in priority order
   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_CLEAR = 2'd1,
      ACT_LOAD  = 2'd2,
      ACT_STEP  = 2'd3
   } cnt_action_e;

   // Ceiling log2, used to size the prescaler phase register
   function automatic int clog2(input int unsigned value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((longint'(1) << i) < longint'(value)) begin
            result = i + 1;
         end
      end
      return clog2_floor_one(result);
   endfunction

   // A register needs at least one bit even when the range collapses
   function automatic int clog2_floor_one(input int bits);
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/contador_prescaler.sv
// Clock-enable prescaler: emits one ptick every PRESCALE enabled cycles.
module contador_prescaler
   import contador_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic ptick
);

   generate
      if (PRESCALE <= 1) begin : g_bypass
         // Every enabled cycle is a count step, so no phase state is kept
         logic unused_inputs;
         assign unused_inputs = ^{clk, reset, restart};
         assign ptick = enable;
      end else begin : g_count
         localparam int PW = clog2(PRESCALE);
         localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

         logic [PW-1:0] phase;

         assign ptick = enable && (phase == LAST_PHASE);

         // Phase advances only on enabled cycles; clear/load and reset restart a full period
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               phase <= '0;
            end else if (restart) begin
               phase <= '0;
            end else if (enable) begin
               phase <= ptick ? '0 : phase + PW'(1);
            end
         end
      end
   endgenerate

endmodule

// File: rtl/contador_param.sv
// Parametrised up/down counter with clear, load, wrap/saturate and prescaled enable.
module contador_param
   import contador_pkg::*;
#(
   parameter int unsigned     WIDTH    = 8,
   parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
   parameter int unsigned     SATURATE = MODE_WRAP,
   parameter int unsigned     PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_down,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             step
);

   // Arithmetic is carried one bit wider so the bound compares never overflow
   localparam int unsigned      EW       = WIDTH + 1;
   localparam logic [WIDTH:0]   MAX_EXT  = EW'(MAX_VAL);
   localparam logic [WIDTH-1:0] MAX_CNT  = MAX_EXT[WIDTH-1:0];
   localparam logic             SAT_MODE = (SATURATE == MODE_SAT);

   logic           ptick;
   cnt_action_e    action;
   logic [WIDTH:0] count_ext;
   logic [WIDTH:0] load_ext;
   logic [WIDTH:0] step_sum;
   logic [WIDTH:0] step_next;
   logic           step_wrap;
   logic           step_moves;
   logic           at_top;
   logic           at_bottom;
   logic           at_bound;
   logic [WIDTH-1:0] load_clamped;
   logic           unused_msb;

   contador_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .restart (clear | load),
      .ptick   (ptick)
   );

   assign count_ext = {1'b0, count};
   assign load_ext  = {1'b0, load_val};
   assign at_top    = (count_ext >= MAX_EXT);
   assign at_bottom = (count_ext == '0);
   assign at_bound  = (up_down == CNT_UP) ? at_top : at_bottom;
   assign step_sum  = (up_down == CNT_UP) ? count_ext + EW'(1) : count_ext - EW'(1);

   assign load_clamped = (load_ext > MAX_EXT) ? MAX_CNT : load_val;
   assign unused_msb   = step_next[WIDTH];

   // Terminal count looks at the live direction, so a direction flip shows at once
   assign tc = (up_down == CNT_UP) ? (count == MAX_CNT) : (count == '0);

   // Resolve the edge action: clear beats load, load beats a pending step
   always_comb begin
      action = ACT_HOLD;
      if (clear) begin
         action = ACT_CLEAR;
      end else if (load) begin
         action = ACT_LOAD;
      end else if (ptick) begin
         action = ACT_STEP;
      end
   end

   // Work out where a step would take the count and whether it crosses a bound
   always_comb begin
      step_next  = count_ext;
      step_wrap  = 1'b0;
      step_moves = 1'b0;
      if (at_bound) begin
         if (!SAT_MODE) begin
            step_next  = (up_down == CNT_UP) ? '0 : MAX_EXT;
            step_wrap  = 1'b1;
            step_moves = 1'b1;
         end
      end else begin
         step_next  = step_sum;
         step_moves = 1'b1;
      end
   end

   // Count register and its registered wrap/step pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         wrap  <= 1'b0;
         step  <= 1'b0;
      end else begin
         case (action)
            ACT_CLEAR: begin
               count <= '0;
               wrap  <= 1'b0;
               step  <= 1'b0;
            end
            ACT_LOAD: begin
               count <= load_clamped;
               wrap  <= 1'b0;
               step  <= 1'b0;
            end
            ACT_STEP: begin
               count <= step_next[WIDTH-1:0];
               wrap  <= step_wrap;
               step  <= step_moves;
            end
            default: begin
               wrap  <= 1'b0;
               step  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench for contador_param: four configurations share one stimulus stream.
module tb_contador_param;
   import contador_pkg::*;

   localparam int NI = 4;

   typedef struct {
      int unsigned count;
      int unsigned psc;
      bit          wrap;
      bit          step;
   } mstate_t;

   // Instance configurations: full-range wrap, decade wrap, saturating prescaled, saturating
   int unsigned maxv_tab [NI] = '{255, 9, 200, 200};
   int unsigned wid_tab  [NI] = '{8, 4, 8, 8};
   bit          sat_tab  [NI] = '{1'b0, 1'b0, 1'b1, 1'b1};
   int unsigned pre_tab  [NI] = '{1, 1, 4, 1};

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          up_down;
   logic          clear;
   logic          load;
   logic [7:0]    load_val;
   logic [7:0]    count0;
   logic [3:0]    count1;
   logic [7:0]    count2;
   logic [7:0]    count3;
   logic [NI-1:0] tc;
   logic [NI-1:0] wrap;
   logic [NI-1:0] step;
   logic [31:0]   obs_count [NI];

   mstate_t m [NI];
   int      checks = 0;
   int      errors = 0;

   always #5 clk = ~clk;

   contador_param #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0), .PRESCALE(1)) u0 (
      .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
      .load(load), .load_val(load_val), .count(count0), .tc(tc[0]), .wrap(wrap[0]), .step(step[0]));

   contador_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) u1 (
      .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
      .load(load), .load_val(load_val[3:0]), .count(count1), .tc(tc[1]), .wrap(wrap[1]), .step(step[1]));

   contador_param #(.WIDTH(8), .MAX_VAL(200), .SATURATE(1), .PRESCALE(4)) u2 (
      .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
      .load(load), .load_val(load_val), .count(count2), .tc(tc[2]), .wrap(wrap[2]), .step(step[2]));

   contador_param #(.WIDTH(8), .MAX_VAL(200), .SATURATE(1), .PRESCALE(1)) u3 (
      .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
      .load(load), .load_val(load_val), .count(count3), .tc(tc[3]), .wrap(wrap[3]), .step(step[3]));

   assign obs_count[0] = {24'b0, count0};
   assign obs_count[1] = {28'b0, count1};
   assign obs_count[2] = {24'b0, count2};
   assign obs_count[3] = {24'b0, count3};

   // Reference model: counting modulo MAX+1, a tick every PRESCALE enabled cycles
   function automatic mstate_t model_next(input mstate_t s, input int idx, input bit en,
                                          input bit ud, input bit clr, input bit ld,
                                          input int unsigned lv);
      mstate_t     n;
      int unsigned lim;
      int unsigned modv;
      int unsigned v;
      bit          tick;
      bit          at_bound;
      lim    = maxv_tab[idx];
      modv   = lim + 1;
      v      = lv % (32'd1 << wid_tab[idx]);
      n      = s;
      n.wrap = 1'b0;
      n.step = 1'b0;
      if (clr) begin
         n.count = 0;
         n.psc   = 0;
      end else if (ld) begin
         n.count = (v > lim) ? lim : v;
         n.psc   = 0;
      end else if (en) begin
         tick  = (s.psc + 1 == pre_tab[idx]);
         n.psc = tick ? 0 : s.psc + 1;
         if (tick) begin
            at_bound = ud ? (s.count == lim) : (s.count == 0);
            if (!(at_bound && sat_tab[idx])) begin
               n.count = ud ? (s.count + 1) % modv : (s.count + lim) % modv;
               n.step  = 1'b1;
               n.wrap  = at_bound;
            end
         end
      end
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      bit exp_tc;
      for (int i = 0; i < NI; i++) begin
         exp_tc = up_down ? (m[i].count == maxv_tab[i]) : (m[i].count == 0);
         checkOutput($sformatf("%s_count%0d", tag, i), obs_count[i], m[i].count);
         checkOutput($sformatf("%s_wrap%0d", tag, i), {31'b0, wrap[i]}, {31'b0, m[i].wrap});
         checkOutput($sformatf("%s_step%0d", tag, i), {31'b0, step[i]}, {31'b0, m[i].step});
         checkOutput($sformatf("%s_tc%0d", tag, i), {31'b0, tc[i]}, {31'b0, exp_tc});
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < NI; i++) begin
         m[i].count = 0;
         m[i].psc   = 0;
         m[i].wrap  = 1'b0;
         m[i].step  = 1'b0;
      end
   endtask

   task automatic applyStimulus(input bit en, input bit ud, input bit clr, input bit ld,
                                input logic [7:0] lv, input string tag);
      enable   = en;
      up_down  = ud;
      clear    = clr;
      load     = ld;
      load_val = lv;
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
         m[i] = model_next(m[i], i, en, ud, clr, ld, {24'b0, lv});
      end
      @(negedge clk);
      checkAll(tag);
   endtask

   initial begin
      reset    = 1'b0;
      enable   = 1'b0;
      up_down  = 1'b0;
      clear    = 1'b0;
      load     = 1'b0;
      load_val = 8'd0;
      modelReset();
      #12;
      $display("[TB] reset state");
      checkAll("reset");
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] full-range up count and wrap");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, "clr1");
      repeat (255) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "up");
      checkOutput("u0_at_max", obs_count[0], 32'd255);
      checkOutput("u0_tc_at_max", {31'b0, tc[0]}, 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "u0wrap");
      checkOutput("u0_wrapped", obs_count[0], 32'd0);
      checkOutput("u0_wrap_pulse", {31'b0, wrap[0]}, 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "idle");
      checkOutput("u0_wrap_one_cycle", {31'b0, wrap[0]}, 32'd0);

      $display("[TB] decade down count");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, "clr2");
      checkOutput("u1_tc_down_zero", {31'b0, tc[1]}, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "down");
      checkOutput("u1_down_wrap_val", obs_count[1], 32'd9);
      checkOutput("u1_down_wrap_pulse", {31'b0, wrap[1]}, 32'd1);
      repeat (9) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "down");
      checkOutput("u1_ten_steps", obs_count[1], 32'd0);
      up_down = 1'b1;
      #1;
      checkOutput("u1_tc_flip_up", {31'b0, tc[1]}, 32'd0);
      up_down = 1'b0;
      #1;
      checkOutput("u1_tc_flip_down", {31'b0, tc[1]}, 32'd1);

      $display("[TB] load clamp and saturation");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'd250, "load250");
      checkOutput("u3_clamped", obs_count[3], 32'd200);
      repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "sat");
      checkOutput("u3_sat_hold", obs_count[3], 32'd200);
      checkOutput("u3_sat_step", {31'b0, step[3]}, 32'd0);
      checkOutput("u3_sat_wrap", {31'b0, wrap[3]}, 32'd0);
      checkOutput("u3_sat_tc", {31'b0, tc[3]}, 32'd1);

      $display("[TB] prescaler phase");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, "clr4");
      repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "pre");
      checkOutput("u2_after12", obs_count[2], 32'd3);
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "pre_a");
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "pre_gap");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "pre_b");
      checkOutput("u2_not_yet", obs_count[2], 32'd3);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "pre_c");
      checkOutput("u2_delayed_step", obs_count[2], 32'd4);
      checkOutput("u2_delayed_pulse", {31'b0, step[2]}, 32'd1);

      $display("[TB] clear/load priority");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'd7, "clr_ld");
      checkOutput("clear_wins", obs_count[0], 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd7, "ld7");
      checkOutput("load_over_step", obs_count[0], 32'd7);
      checkOutput("load_no_step", {31'b0, step[0]}, 32'd0);
      checkOutput("load_no_wrap", {31'b0, wrap[0]}, 32'd0);

      $display("[TB] asynchronous reset mid-prescale");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'd5, "ld5");
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "ph2");
      checkOutput("u2_before_reset", obs_count[2], 32'd5);
      #2;
      reset = 1'b0;
      #1;
      modelReset();
      checkOutput("u2_async_reset", obs_count[2], 32'd0);
      checkOutput("u0_async_reset", obs_count[0], 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "post_rst");
      checkOutput("u2_no_early_step", obs_count[2], 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "post_rst4");
      checkOutput("u2_full_period", obs_count[2], 32'd1);

      $display("[TB] randomized traffic");
      repeat (300) begin
         applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                       8'($urandom), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
